// File: rtl/uart_cmd_rx_if.sv
// Bundle of the serial input and the command/status outputs of uart_cmd_rx.
// The slave modport is the receiver's view; master is the host-side view.
interface uart_cmd_rx_if;
    logic        rx_in;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_data;
    logic        frame_err;
    logic        chk_err;
    logic        busy;

    modport master (
        output rx_in,
        input  cmd_valid, cmd_code, cmd_data, frame_err, chk_err, busy
    );

    modport slave (
        input  rx_in,
        output cmd_valid, cmd_code, cmd_data, frame_err, chk_err, busy
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// Host-to-board command receiver: 8N1 deserialiser running on a 16x clock,
// followed by a parser for 5-byte frames {HEADER, cmd, dh, dl, cmd^dh^dl}.
module uart_cmd_rx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter logic [7:0]  HEADER     = 8'hA5,
    parameter int unsigned TIMEOUT    = 480
) (
    input logic          clock,
    input logic          reset,
    uart_cmd_rx_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(OVERSAMPLE + 1);
    localparam int unsigned      TO_W_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned      TO_W     = (TO_W_RAW > 9) ? TO_W_RAW : 9;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(OVERSAMPLE);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } bit_state_t;

    typedef enum logic [2:0] {
        P_HDR,
        P_CMD,
        P_DH,
        P_DL,
        P_CHK
    } parse_state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rx_s;
    logic             w_start_edge;

    bit_state_t       r_bstate;
    logic [CNT_W-1:0] r_bcnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_frame_err;

    parse_state_t     r_pstate;
    logic [TO_W-1:0]  r_idle_cnt;
    logic [7:0]       r_sh_cmd;
    logic [7:0]       r_sh_dh;
    logic [7:0]       r_sh_dl;
    logic             r_cmd_valid;
    logic             r_chk_err;
    logic [7:0]       r_cmd_code;
    logic [15:0]      r_cmd_data;
    logic             r_busy;

    assign w_rx_s       = r_sync2;
    assign w_start_edge = (r_bstate == S_IDLE) && !w_rx_s;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // Bit FSM: start validation, 8 LSB-first data bits, stop check, break hold-off.
    // r_bcnt counts cycles since the start edge (or since the previous sample),
    // so the start sample lands OVERSAMPLE/2-1 cycles after the edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bstate     <= S_IDLE;
            r_bcnt       <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_bstate)
                S_IDLE: begin
                    r_bcnt <= '0;
                    if (!w_rx_s) begin
                        r_bstate <= S_START;
                        r_bcnt   <= CNT_ONE;
                    end
                end
                S_START: begin
                    if (r_bcnt == HALF_M1) begin
                        if (w_rx_s) begin
                            r_bstate <= S_IDLE;
                            r_bcnt   <= '0;
                        end else begin
                            r_bstate  <= S_DATA;
                            r_bcnt    <= CNT_ONE;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_bcnt <= r_bcnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (r_bcnt == FULL) begin
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bcnt    <= CNT_ONE;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_bstate <= S_STOP;
                        end
                    end else begin
                        r_bcnt <= r_bcnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (r_bcnt == FULL) begin
                        r_bcnt <= '0;
                        if (w_rx_s) begin
                            r_byte_valid <= 1'b1;
                            r_bstate     <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_bstate    <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_bcnt <= r_bcnt + CNT_ONE;
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_bstate <= S_IDLE;
                    end
                end
                default: begin
                    r_bstate <= S_IDLE;
                    r_bcnt   <= '0;
                end
            endcase
        end
    end

    // Parser FSM with inter-byte idle timeout; outputs load only on an accepted frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pstate    <= P_HDR;
            r_idle_cnt  <= '0;
            r_sh_cmd    <= '0;
            r_sh_dh     <= '0;
            r_sh_dl     <= '0;
            r_cmd_valid <= 1'b0;
            r_chk_err   <= 1'b0;
            r_cmd_code  <= '0;
            r_cmd_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_chk_err   <= 1'b0;
            if (r_byte_valid) begin
                r_idle_cnt <= '0;
                case (r_pstate)
                    P_HDR: begin
                        if (r_shift == HEADER) begin
                            r_pstate <= P_CMD;
                            r_busy   <= 1'b1;
                        end
                    end
                    P_CMD: begin
                        r_sh_cmd <= r_shift;
                        r_pstate <= P_DH;
                    end
                    P_DH: begin
                        r_sh_dh  <= r_shift;
                        r_pstate <= P_DL;
                    end
                    P_DL: begin
                        r_sh_dl  <= r_shift;
                        r_pstate <= P_CHK;
                    end
                    P_CHK: begin
                        if (r_shift == (r_sh_cmd ^ r_sh_dh ^ r_sh_dl)) begin
                            r_cmd_code  <= r_sh_cmd;
                            r_cmd_data  <= {r_sh_dh, r_sh_dl};
                            r_cmd_valid <= 1'b1;
                        end else begin
                            r_chk_err <= 1'b1;
                        end
                        r_pstate <= P_HDR;
                        r_busy   <= 1'b0;
                    end
                    default: begin
                        r_pstate <= P_HDR;
                        r_busy   <= 1'b0;
                    end
                endcase
            end else if (r_frame_err) begin
                r_pstate   <= P_HDR;
                r_busy     <= 1'b0;
                r_idle_cnt <= '0;
            end else if (w_start_edge) begin
                r_idle_cnt <= '0;
            end else if ((r_pstate != P_HDR) && (r_bstate == S_IDLE)) begin
                if (r_idle_cnt == TO_LIM) begin
                    r_pstate   <= P_HDR;
                    r_busy     <= 1'b0;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + TO_ONE;
                end
            end
        end
    end

    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_code  = r_cmd_code;
    assign bus.cmd_data  = r_cmd_data;
    assign bus.frame_err = r_frame_err;
    assign bus.chk_err   = r_chk_err;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: the driver serialises bytes and feeds a
// frame-level reference model that queues expected events with their cycle;
// an independent monitor pops and compares whenever the DUT pulses.
module tb_uart_cmd_rx;

    localparam int unsigned OS       = 16;
    localparam logic [7:0]  HDR      = 8'hA5;
    localparam int unsigned TO       = 480;
    // Cycles from rx_in falling (start bit of the last byte) to the pulse:
    // 2 synchroniser cycles + 153 to cmd_valid/chk_err, + 152 to frame_err.
    localparam int unsigned LAT_CMD  = 155;
    localparam int unsigned LAT_FERR = 154;

    typedef enum logic [1:0] {EV_CMD, EV_CHK, EV_FERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [7:0]  code;
        logic [15:0] data;
        int unsigned when;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rst_q = 1'b0;
    int unsigned cyc   = 0;

    ev_t         sb[$];
    logic [7:0]  frame_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mon_code = '0;
    logic [15:0] mon_data = '0;

    uart_cmd_rx_if bus ();

    uart_cmd_rx #(
        .OVERSAMPLE(OS),
        .HEADER    (HDR),
        .TIMEOUT   (TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference: collect bytes once a header is seen; the fifth byte
    // decides between an accepted command and a checksum error.
    function automatic void model_byte(input logic [7:0] b, input int unsigned t_start);
        if (frame_q.size() == 0) begin
            if (b == HDR) frame_q.push_back(b);
        end else begin
            frame_q.push_back(b);
            if (frame_q.size() == 5) begin
                ev_t e;
                e.code = frame_q[1];
                e.data = {frame_q[2], frame_q[3]};
                e.when = t_start + LAT_CMD;
                e.kind = (frame_q[4] == (frame_q[1] ^ frame_q[2] ^ frame_q[3])) ? EV_CMD : EV_CHK;
                sb.push_back(e);
                frame_q.delete();
            end
        end
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle(input int unsigned n);
        bus.rx_in = 1'b1;
        tick(n);
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b, cyc);
        bus.rx_in = 1'b0;
        tick(OS);
        for (int i = 0; i < 8; i++) begin
            bus.rx_in = b[i];
            tick(OS);
        end
        bus.rx_in = 1'b1;
        tick(OS);
    endtask

    task automatic glitch(input int unsigned len);
        bus.rx_in = 1'b0;
        tick(len);
        bus.rx_in = 1'b1;
        tick(12);
    endtask

    task automatic send_break(input int unsigned len);
        ev_t e;
        e.kind = EV_FERR;
        e.code = '0;
        e.data = '0;
        e.when = cyc + LAT_FERR;
        sb.push_back(e);
        frame_q.delete();
        bus.rx_in = 1'b0;
        tick(len);
        bus.rx_in = 1'b1;
        tick(20);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] ck);
        send_byte(HDR);
        send_byte(c);
        send_byte(dh);
        send_byte(dl);
        send_byte(ck);
    endtask

    // Monitor: reset values, event matching against the scoreboard, output hold.
    initial begin
        ev_t        e;
        logic [2:0] exp_bits;
        forever begin
            @(negedge clock);
            if (!rst_q) begin
                check("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
                check("rst_chk_err", {31'd0, bus.chk_err}, 32'd0);
                check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
                check("rst_busy", {31'd0, bus.busy}, 32'd0);
                check("rst_cmd_code", {24'd0, bus.cmd_code}, 32'd0);
                check("rst_cmd_data", {16'd0, bus.cmd_data}, 32'd0);
                mon_code = '0;
                mon_data = '0;
            end else begin
                if (bus.cmd_valid || bus.chk_err || bus.frame_err) begin
                    check("cmd_chk_overlap", {31'd0, bus.cmd_valid & bus.chk_err}, 32'd0);
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_pulse: cmd_valid=%b chk_err=%b frame_err=%b, expected none (cycle %0d)",
                                 bus.cmd_valid, bus.chk_err, bus.frame_err, cyc);
                    end else begin
                        e = sb.pop_front();
                        case (e.kind)
                            EV_CMD:  exp_bits = 3'b100;
                            EV_CHK:  exp_bits = 3'b010;
                            default: exp_bits = 3'b001;
                        endcase
                        check("event_kind", {29'd0, bus.cmd_valid, bus.chk_err, bus.frame_err},
                              {29'd0, exp_bits});
                        check("event_cycle", cyc, e.when);
                        if (e.kind == EV_CMD) begin
                            check("cmd_code", {24'd0, bus.cmd_code}, {24'd0, e.code});
                            check("cmd_data", {16'd0, bus.cmd_data}, {16'd0, e.data});
                            mon_code = e.code;
                            mon_data = e.data;
                        end
                        if (e.kind != EV_FERR) begin
                            check("busy_fall", {31'd0, bus.busy}, 32'd0);
                        end
                    end
                end
                check("code_hold", {24'd0, bus.cmd_code}, {24'd0, mon_code});
                check("data_hold", {16'd0, bus.cmd_data}, {16'd0, mon_data});
            end
        end
    end

    // Driver: directed scenarios, then randomized frames.
    initial begin
        int unsigned kind;
        int unsigned n;
        logic [7:0]  c;
        logic [7:0]  dh;
        logic [7:0]  dl;
        logic [7:0]  ck;
        logic [7:0]  g;

        bus.rx_in = 1'b1;
        reset     = 1'b0;
        @(posedge clock);
        #1;
        tick(4);
        reset = 1'b1;
        idle(8);

        // Valid frame, back-to-back bytes.
        send_byte(HDR);
        check("busy_after_header", {31'd0, bus.busy}, 32'd1);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h27);
        idle(20);

        // Bad checksum: outputs keep 01/1234.
        send_frame(8'h01, 8'h12, 8'h34, 8'h00);
        idle(20);

        // Glitch then garbage before a valid frame.
        glitch(4);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'h02, 8'h00, 8'h10, 8'h12);
        idle(20);

        // Break while the parser waits for data high.
        send_byte(HDR);
        send_byte(8'h03);
        send_break(400);
        check("busy_after_break", {31'd0, bus.busy}, 32'd0);
        send_frame(8'h03, 8'hAB, 8'hCD, 8'h65);
        idle(20);

        // Timeout after header + command; trailing bytes dropped.
        send_byte(HDR);
        send_byte(8'h01);
        idle(500);
        frame_q.delete();
        check("busy_after_timeout", {31'd0, bus.busy}, 32'd0);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h27);
        idle(20);

        // Reset during data bit 3 of the command byte.
        send_byte(HDR);
        c = 8'h01;
        bus.rx_in = 1'b0;
        tick(OS);
        for (int i = 0; i < 3; i++) begin
            bus.rx_in = c[i];
            tick(OS);
        end
        bus.rx_in = c[3];
        tick(OS / 2);
        bus.rx_in = 1'b1;
        reset = 1'b0;
        frame_q.delete();
        tick(3);
        reset = 1'b1;
        idle(10);
        send_frame(8'h01, 8'h12, 8'h34, 8'h27);
        idle(20);

        // Randomized frames against the reference model.
        for (int it = 0; it < 25; it++) begin
            kind = $urandom_range(0, 4);
            c    = 8'($urandom);
            dh   = 8'($urandom);
            dl   = 8'($urandom);
            ck   = c ^ dh ^ dl;
            if (kind == 1) ck = ck ^ 8'($urandom_range(1, 255));
            if (kind == 2) begin
                g = 8'($urandom);
                if (g == HDR) g = 8'h00;
                send_byte(g);
                idle($urandom_range(0, 30));
            end
            if (kind == 4) glitch($urandom_range(1, 5));
            if (kind == 3) begin
                n = $urandom_range(1, 3);
                send_byte(HDR);
                send_byte(c);
                if (n >= 2) send_byte(dh);
                if (n >= 3) send_byte(dl);
                idle(500);
                frame_q.delete();
                check("busy_after_rand_timeout", {31'd0, bus.busy}, 32'd0);
            end else begin
                send_byte(HDR);
                idle($urandom_range(0, 20));
                send_byte(c);
                idle($urandom_range(0, 20));
                send_byte(dh);
                idle($urandom_range(0, 20));
                send_byte(dl);
                idle($urandom_range(0, 20));
                send_byte(ck);
            end
            idle($urandom_range(0, 40));
        end

        idle(50);
        for (int w = 0; w < 400 && sb.size() != 0; w++) tick(1);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Host-to-board command receiver: the receive direction of the board's UART link, which otherwise only streams ADC frames to the host. It deserialises 8N1 bytes from `rx_in` using a 16x-oversampling clock. It parses fixed 5-byte command frames (header, command, data high, data low, XOR checksum) and emits one validated command per frame. Its outputs feed the scan and ADC control logic and share the `clock_uart` domain with the transmitter.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: clock cycles per bit. Must be even and ≥ 4.
- `HEADER`, default 8'hA5: frame start byte.
- `TIMEOUT`, default 480: inter-byte idle limit in clock cycles (3 byte-times at 16x).

Ports:
- `clock`  in  1: 16x baud clock (`clock_uart`).
- `reset`  in  1: synchronous, active-low.
- `rx_in`  in  1: asynchronous serial line, idle high.
- `cmd_valid`  out  1: one-cycle pulse, frame accepted.
- `cmd_code`  out  8: command byte of the last accepted frame.
- `cmd_data`  out  16: {data high, data low} of the last accepted frame.
- `frame_err`  out  1: one-cycle pulse, stop bit sampled low.
- `chk_err`  out  1: one-cycle pulse, checksum mismatch.
- `busy`  out  1: high while the parser is not in P_HDR.

## Operation
- **Reset values:** all outputs 0. Synchroniser flops 1. Both FSMs in their idle state. Counters 0.
- **Input synchroniser:** `rx_in` passes through 2 flops; the result is `rx_s`. All logic uses `rx_s` only.
- **Bit FSM (IDLE, START, DATA, STOP, WAIT_HIGH):**
  - IDLE: when `rx_s` = 0, go to START with the counter cleared.
  - START: at count OVERSAMPLE/2−1, sample `rx_s`. If 1, it was a glitch: return to IDLE with no output. If 0, clear the counter and go to DATA.
  - DATA: sample every OVERSAMPLE cycles, 8 bits, LSB first, shifted into the byte register.
  - STOP: sample after OVERSAMPLE cycles. If 1, pulse the internal `byte_valid` and go to IDLE. If 0, pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE. A held break therefore yields exactly one `frame_err`.
- **Parser FSM (P_HDR, P_CMD, P_DH, P_DL, P_CHK):** advances on `byte_valid`.
  - P_HDR: a byte equal to HEADER moves to P_CMD. Any other byte is silently dropped.
  - P_CMD, P_DH, P_DL: latch the byte into a shadow register and advance.
  - P_CHK: if byte = cmd ^ dh ^ dl, load `cmd_code`/`cmd_data` from the shadows and pulse `cmd_valid`. Otherwise pulse `chk_err`; the outputs keep their old values. In both cases return to P_HDR.
- **Timeout:** a 9-bit-minimum idle counter clears on every `byte_valid` and every START entry. It counts while the parser is not in P_HDR and the bit FSM is in IDLE. When it reaches TIMEOUT, the parser goes to P_HDR. No error pulse is produced and the shadows are discarded.
- **Framing error mid-frame:** `frame_err` also forces the parser to P_HDR.
- **Reset mid-byte or mid-frame:** all state aborts and no pulses are produced. The next valid start bit after reset is received normally. Reset has priority over every other event.
- **Output stability:** `cmd_code`/`cmd_data` change only in the same cycle that `cmd_valid` is high and hold until the next accepted frame.

## Timing
- Let T0 be the first cycle with `rx_s` = 0 in IDLE. `rx_s` lags `rx_in` by 2 cycles.
- Start sample: T0+OVERSAMPLE/2−1, i.e. T0+7.
- Data bit i (0..7) sample: T0+7+16·(i+1).
- Stop sample: T0+151.
- `byte_valid` or `frame_err`: high in T0+152 only.
- `cmd_valid` or `chk_err`: high in the cycle after the checksum byte's `byte_valid`, i.e. T0+153 relative to the checksum byte.
- `busy`: rises the cycle after the header's `byte_valid`. Falls in the same cycle as `cmd_valid`/`chk_err`, or the cycle after a timeout or `frame_err`.
- Back-to-back bytes (stop bit immediately followed by a start bit) are accepted. IDLE is entered on the cycle after the stop sample, so a new start edge can be detected from then.
- `cmd_valid`, `chk_err` and `frame_err` are never high for more than 1 cycle. `cmd_valid` and `chk_err` are never high together.

## Test plan
- **Valid frame:** reset low for 4 cycles, then send A5 01 12 34 27 back-to-back. Expect `cmd_valid` = 1 for exactly one cycle at the predicted T0+153, `cmd_code` = 01, `cmd_data` = 1234, and no errors.
- **Bad checksum:** send A5 01 12 34 00. Expect a single `chk_err` pulse, no `cmd_valid`, and the outputs still showing the previous 01/1234.
- **Glitch and garbage:** drive a 4-cycle low pulse on `rx_in`, then send 00 FF A5 02 00 10 12. Expect no byte from the glitch and one command with code 02, data 0010.
- **Break:** hold `rx_in` low for 400 cycles during P_DH, then send a full frame A5 03 AB CD 65. Expect exactly one `frame_err`, `busy` falling, and then a command with code 03, data ABCD.
- **Timeout:** send A5 01, idle for 500 cycles, then send 12 34 27. Expect no `cmd_valid` and no `chk_err`, `busy` = 0 after the timeout, and all three trailing bytes dropped in P_HDR.
- **Reset mid-byte:** assert reset during data bit 3 of the command byte. Expect all outputs 0 on the next cycle. A following complete frame A5 01 12 34 27 must be received correctly.
